pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline. It drives the hold/flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards, branch/jump redirects and slow data-memory accesses.
- Holds a small FSM plus a wait-timeout counter so multi-cycle memory waits freeze the whole pipe deterministically.

Parameters:
- TO_W, 8, width of the memory-wait timeout counter.
- MEM_TIMEOUT, 200, maximum freeze cycles before forced release (must be < 2^TO_W).

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- id_rs  in  5  Rs field of instruction in ID
- id_rt  in  5  Rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads Rt as a source
- id_jump  in  1  jump (J/JAL/JR/JALR) decoded in ID
- ex_memrd  in  1  instruction in EX is a load
- ex_rt  in  5  load destination register in EX
- ex_branch_taken  in  1  branch resolved taken in EX
- mem_req  in  1  MEM stage access to slow space
- mem_ready  in  1  slow space completes this cycle
- pc_hold  out  1  PC keeps value
- if_id_hold  out  1  IF/ID keeps value
- if_id_flush  out  1  IF/ID loads zero (NOP)
- id_ex_flush  out  1  ID/EX loads zero (bubble)
- pipe_freeze  out  1  ID/EX, EX/MEM, MEM/WB keep value
- mem_timeout  out  1  sticky: a wait was aborted by timeout
- busy  out  1  FSM not in RUN

Behaviour:
- Reset: state=RUN, counter=0, mem_timeout=0. All control outputs are 0 in the reset cycle and in the following cycle.
- States:
  - RUN: normal operation.
  - WAIT: memory freeze.
  - RECOVER: one cycle after the wait ends, during which freeze is released and no new wait is accepted.
- Hazard terms (combinational from inputs):
  - lu = ex_memrd & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
  - wait_need = mem_req & !mem_ready.
- Output priority each cycle:
  1. freeze: state==WAIT, or (state==RUN & wait_need). Asserts pc_hold, if_id_hold, pipe_freeze. All flushes are suppressed; a pending branch or load-use is re-evaluated after the freeze.
  2. ex_branch_taken: if_id_flush=1, id_ex_flush=1. No hold. The load-use check is ignored because the ID instruction is squashed.
  3. lu: pc_hold=1, if_id_hold=1, id_ex_flush=1. Exactly one bubble per hazard, because the load advances next cycle.
  4. id_jump: if_id_flush=1 only.
- FSM transitions:
  - RUN -> WAIT when wait_need; counter is cleared to 1.
  - WAIT -> RECOVER on mem_ready, or when counter==MEM_TIMEOUT. Timeout sets mem_timeout, which stays set until reset.
  - WAIT self-loop otherwise, counter+1. Counter saturates and never wraps.
  - RECOVER -> RUN unconditionally. Priorities 2-4 apply in RECOVER.
- mem_req & mem_ready in the same cycle while in RUN: no freeze, stay in RUN (zero-wait access).
- busy = (state != RUN).
- Reset asserted mid-WAIT: next cycle is RUN with outputs cleared. No partial state is retained.
- if_id_hold and if_id_flush are never both 1. If a flush and a hold would coincide, the freeze suppresses the flush.

Optional Feature:
- Macro: PIPE_HAZARD_STATS_EN.
- When defined, adds three outputs: stall_cnt, flush_cnt and wait_cnt, each 32 bits.
  - stall_cnt counts load-use cycles, flush_cnt counts flush cycles, wait_cnt counts freeze cycles.
  - All three reset to 0 and wrap modulo 2^32.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - the state encoding localparams RUN=2'd0, WAIT=2'd1, RECOVER=2'd2;
  - the register-zero constant 5'd0;
  - the MEM_TIMEOUT default.
- Natural sub-module: hazard_detect, the purely combinational lu/priority logic. The FSM, counter and optional stats stay in pipe_hazard_ctrl.

Test Plan:
- Load-use: ex_memrd=1, ex_rt=5, id_rs=5 -> one cycle of pc_hold=1, if_id_hold=1, id_ex_flush=1. Next cycle all 0.
- ex_rt=0 with id_rs=0 and ex_memrd=1 -> no stall. id_uses_rt=0 with ex_rt==id_rt=7 -> no stall.
- Branch and load-use together: ex_branch_taken=1 and lu true -> if_id_flush=1, id_ex_flush=1, pc_hold=0.
- Memory wait: mem_req=1, mem_ready low for 3 cycles then high:
  - pc_hold, if_id_hold and pipe_freeze are high for 4 cycles (3 wait cycles plus the ready cycle).
  - busy is high through WAIT and RECOVER, then returns to RUN.
- Timeout: MEM_TIMEOUT=4, mem_ready never rises -> freeze lasts 4 cycles, mem_timeout=1 and stays sticky, then RECOVER, then RUN.
- Reset during WAIT -> next cycle all outputs 0, busy=0, mem_timeout=0. With PIPE_HAZARD_STATS_EN defined, all counters read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT    = 2'd1,
        RECOVER = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int MEM_TIMEOUT_DEF = 200;

    typedef struct packed {
        logic pc_hold;
        logic if_id_hold;
        logic if_id_flush;
        logic id_ex_flush;
        logic pipe_freeze;
    } ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use detection and stall/flush priority encoding.
module hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic       active,
    input  logic       freeze,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       id_jump,
    input  logic       ex_memrd,
    input  logic [4:0] ex_rt,
    input  logic       ex_branch_taken,
    output ctrl_t      ctrl,
    output logic       lu_sel
);

    logic lu;

    assign lu = ex_memrd && (ex_rt != REG_ZERO) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // Freeze outranks every flush so IF/ID is never held and flushed together.
    always_comb begin
        ctrl   = '0;
        lu_sel = 1'b0;
        if (!active) begin
            ctrl = '0;
        end else if (freeze) begin
            ctrl.pc_hold     = 1'b1;
            ctrl.if_id_hold  = 1'b1;
            ctrl.pipe_freeze = 1'b1;
        end else if (ex_branch_taken) begin
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
        end else if (lu) begin
            ctrl.pc_hold     = 1'b1;
            ctrl.if_id_hold  = 1'b1;
            ctrl.id_ex_flush = 1'b1;
            lu_sel           = 1'b1;
        end else if (id_jump) begin
            ctrl.if_id_flush = 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe with memory-wait FSM and timeout.
// Optional event counters enabled by PIPE_HAZARD_STATS_EN.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int TO_W        = 8,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_jump,
    input  logic        ex_memrd,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_hold,
    output logic        if_id_hold,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        pipe_freeze,
    output logic        mem_timeout,
`ifdef PIPE_HAZARD_STATS_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic [31:0] wait_cnt,
`endif
    output logic        busy
);

    state_t          state;
    logic [TO_W-1:0] cnt;
    logic            rst_q;
    logic            to_q;
    logic            active;
    logic            wait_need;
    logic            freeze;
    logic            lu_sel;
    ctrl_t           ctrl;

    // Controls stay quiet for the reset cycle and the one after it.
    assign active    = !(reset || rst_q);
    assign wait_need = mem_req && !mem_ready;
    assign freeze    = (state == WAIT) || ((state == RUN) && wait_need);

    hazard_detect u_hd (
        .active          (active),
        .freeze          (freeze),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .id_jump         (id_jump),
        .ex_memrd        (ex_memrd),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .ctrl            (ctrl),
        .lu_sel          (lu_sel)
    );

    assign pc_hold     = ctrl.pc_hold;
    assign if_id_hold  = ctrl.if_id_hold;
    assign if_id_flush = ctrl.if_id_flush;
    assign id_ex_flush = ctrl.id_ex_flush;
    assign pipe_freeze = ctrl.pipe_freeze;
    assign mem_timeout = to_q && !reset;
    assign busy        = (state != RUN) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
            to_q  <= 1'b0;
            rst_q <= 1'b1;
        end else begin
            rst_q <= 1'b0;
            case (state)
                RUN: begin
                    if (!rst_q && wait_need) begin
                        state <= WAIT;
                        cnt   <= TO_W'(1);
                    end
                end
                WAIT: begin
                    if (mem_ready) begin
                        state <= RECOVER;
                    end else if (cnt == TO_W'(MEM_TIMEOUT)) begin
                        state <= RECOVER;
                        to_q  <= 1'b1;
                    end else if (cnt != {TO_W{1'b1}}) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RECOVER: state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

`ifdef PIPE_HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            stall_cnt <= stall_cnt + {31'd0, lu_sel};
            flush_cnt <= flush_cnt + {31'd0, (ctrl.if_id_flush || ctrl.id_ex_flush)};
            wait_cnt  <= wait_cnt + {31'd0, ctrl.pipe_freeze};
        end
    end
`else
    logic unused_lu;
    assign unused_lu = lu_sel;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT=4).
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic       id_uses_rt = 0, id_jump = 0, ex_memrd = 0, ex_branch_taken = 0;
    logic       mem_req = 0, mem_ready = 0;
    logic       pc_hold, if_id_hold, if_id_flush, id_ex_flush, pipe_freeze, mem_timeout, busy;
`ifdef PIPE_HAZARD_STATS_EN
    logic [31:0] stall_cnt, flush_cnt, wait_cnt;
`endif

    int n_chk = 0;
    int n_fail = 0;
    logic [6:0] obs, exp_v;

    // {pc_hold, if_id_hold, if_id_flush, id_ex_flush, pipe_freeze, mem_timeout, busy}
    assign obs = {pc_hold, if_id_hold, if_id_flush, id_ex_flush, pipe_freeze, mem_timeout, busy};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TO_W(8), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
        .ex_memrd(ex_memrd), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .pipe_freeze(pipe_freeze), .mem_timeout(mem_timeout),
`ifdef PIPE_HAZARD_STATS_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt),
`endif
        .busy(busy)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = '0; id_rt = '0; ex_rt = '0; id_uses_rt = 0; id_jump = 0;
        ex_memrd = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic test_reset();
        cyc(); ex_memrd = 1; ex_rt = 5'd5; id_rs = 5'd5; #2;
        exp_v = 7'b0000000; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reset_cycle got=%b exp=%b", obs, exp_v); end
        cyc(); reset = 0; #2;
        exp_v = 7'b0000000; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL post_reset_cycle got=%b exp=%b", obs, exp_v); end
        cyc(); #2;
        exp_v = 7'b1101000; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL first_active_lu got=%b exp=%b", obs, exp_v); end
        idle();
    endtask

    task automatic test_load_use();
        cyc(); ex_memrd = 1; ex_rt = 5'd5; id_rs = 5'd5; #2;
        exp_v = 7'b1101000; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL lu_rs got=%b exp=%b", obs, exp_v); end
        cyc(); idle(); #2;
        exp_v = 7'b0000000; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL lu_release got=%b exp=%b", obs, exp_v); end
        cyc(); ex_memrd = 1; ex_rt = 5'd0; id_rs = 5'd0; #2;
        exp_v = 7'b0000000; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL lu_r0 got=%b exp=%b", obs, exp_v); end
        cyc(); ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 0; #2;
        exp_v = 7'b0000000; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL lu_rt_unused got=%b exp=%b", obs, exp_v); end
        cyc(); id_uses_rt = 1; #2;
        exp_v = 7'b1101000; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL lu_rt_used got=%b exp=%b", obs, exp_v); end
        idle();
    endtask

    task automatic test_branch_jump();
        cyc(); ex_memrd = 1; ex_rt = 5'd9; id_rs = 5'd9; ex_branch_taken = 1; #2;
        exp_v = 7'b0011000; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL branch_over_lu got=%b exp=%b", obs, exp_v); end
        cyc(); idle(); id_jump = 1; #2;
        exp_v = 7'b0010000; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL jump_only got=%b exp=%b", obs, exp_v); end
        cyc(); ex_memrd = 1; ex_rt = 5'd9; id_rs = 5'd9; #2;
        exp_v = 7'b1101000; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL lu_over_jump got=%b exp=%b", obs, exp_v); end
        idle();
    endtask

    task automatic test_mem_wait();
        cyc(); mem_req = 1; mem_ready = 0; #2;
        exp_v = 7'b1100100; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL wait_c0 got=%b exp=%b", obs, exp_v); end
        cyc(); ex_branch_taken = 1; id_jump = 1; #2;
        exp_v = 7'b1100101; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL wait_c1_flush_suppressed got=%b exp=%b", obs, exp_v); end
        cyc(); ex_branch_taken = 0; id_jump = 0; #2;
        exp_v = 7'b1100101; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL wait_c2 got=%b exp=%b", obs, exp_v); end
        cyc(); mem_ready = 1; #2;
        exp_v = 7'b1100101; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL wait_ready_cycle got=%b exp=%b", obs, exp_v); end
        cyc(); mem_req = 0; mem_ready = 0; ex_branch_taken = 1; #2;
        exp_v = 7'b0011001; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL recover_branch got=%b exp=%b", obs, exp_v); end
        cyc(); idle(); #2;
        exp_v = 7'b0000000; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL back_to_run got=%b exp=%b", obs, exp_v); end
        cyc(); mem_req = 1; mem_ready = 1; #2;
        exp_v = 7'b0000000; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL zero_wait got=%b exp=%b", obs, exp_v); end
        cyc(); idle(); #2;
        exp_v = 7'b0000000; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL zero_wait_after got=%b exp=%b", obs, exp_v); end
    endtask

    task automatic test_timeout();
        int wait_frz;
        wait_frz = 0;
        cyc(); mem_req = 1; mem_ready = 0; #2;
        exp_v = 7'b1100100; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL to_c0 got=%b exp=%b", obs, exp_v); end
        for (int i = 1; i <= 4; i++) begin
            cyc(); #2;
            if (pipe_freeze && busy) wait_frz++;
            exp_v = 7'b1100101; n_chk++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL to_wait_c%0d got=%b exp=%b", i, obs, exp_v); end
        end
        n_chk++;
        if (wait_frz !== 4) begin n_fail++; $display("FAIL to_freeze_len got=%0d exp=4", wait_frz); end
        cyc(); mem_req = 0; #2;
        exp_v = 7'b0000011; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL to_recover got=%b exp=%b", obs, exp_v); end
        cyc(); #2;
        exp_v = 7'b0000010; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL to_run_sticky got=%b exp=%b", obs, exp_v); end
        cyc(); mem_req = 1; mem_ready = 1; #2;
        cyc(); idle(); #2;
        exp_v = 7'b0000010; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL to_still_sticky got=%b exp=%b", obs, exp_v); end
    endtask

    task automatic test_reset_in_wait();
        cyc(); mem_req = 1; mem_ready = 0; #2;
        cyc(); #2;
        exp_v = 7'b1100111; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL rw_in_wait got=%b exp=%b", obs, exp_v); end
        reset = 1; #1;
        exp_v = 7'b0000000; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL rw_reset_cycle got=%b exp=%b", obs, exp_v); end
        cyc(); reset = 0; #2;
        exp_v = 7'b0000000; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL rw_after_reset got=%b exp=%b", obs, exp_v); end
`ifdef PIPE_HAZARD_STATS_EN
        n_chk++;
        if ({stall_cnt, flush_cnt, wait_cnt} !== 96'd0) begin
            n_fail++; $display("FAIL rw_stats got=%0d/%0d/%0d exp=0/0/0", stall_cnt, flush_cnt, wait_cnt);
        end
`endif
        cyc(); #2;
        exp_v = 7'b1100100; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL rw_new_wait got=%b exp=%b", obs, exp_v); end
        cyc(); idle(); mem_req = 0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_jump();
        test_mem_wait();
        test_timeout();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
